up_counter: RTL and testbench
=============================

Name: up_counter

Overview:
- Free-running binary up-counter: WIDTH-bit internal count register incremented on every rising clock edge.
- Exposes only its most-significant OUT_WIDTH bits as a slow, divided-down output, e.g. for LED/activity indication or a coarse timebase.
- Leaf block; no handshakes, no enable.

Parameters:
- WIDTH, 32, bit width of internal count register counter_value; legal range 1..64.
- OUT_WIDTH, 8, number of MSBs of counter_value driven on out; legal range 1..WIDTH.

Ports:
- clk  input  1  single clock, rising-edge active.
- resetn  input  1  asynchronous active-low reset (one clock; reset is asynchronous and active-low).
- out  output  OUT_WIDTH  equals counter_value[WIDTH-1 : WIDTH-OUT_WIDTH].

Behaviour:
- Internal register named exactly counter_value, width WIDTH. Verification probes it hierarchically (uut.counter_value), so the name and width are mandatory.
- resetn low: counter_value forced to 0 immediately, without waiting for clk; out = 0. Held at 0 for as long as resetn is low, regardless of clk activity.
- resetn high: on each rising clk edge, counter_value <= counter_value + 1, modulo 2^WIDTH.
- First count after reset release: the first rising edge with resetn sampled high gives counter_value = 1.
- Wrap-around: counter_value = 2^WIDTH-1 goes to 0 on the next edge. No sticky flag, no saturation.
- out is a purely combinational slice of counter_value, with no extra register stage.
  - Zero latency relative to counter_value.
  - out increments once every 2^(WIDTH-OUT_WIDTH) clocks.
  - When OUT_WIDTH = WIDTH, out equals counter_value.
- Reset asserted mid-count: count discarded asynchronously; counting restarts from 0 after release.
- Reset deassertion is not internally synchronized. Deassertion must be synchronous to clk upstream, or must occur away from a rising edge.
- Elaboration guard: if OUT_WIDTH > WIDTH or OUT_WIDTH < 1, elaboration fails with a clear error via a generate-time check.
- No X propagation: all outputs are defined from the moment reset is asserted.

Optional Feature:
- Macro: UP_COUNTER_TICK_EN.
- Defined:
  - Adds output port tick (1 bit), placed after out.
  - tick = 1 combinationally when the low (WIDTH-OUT_WIDTH) bits of counter_value are all ones, i.e. out will advance on the next rising edge.
  - If OUT_WIDTH = WIDTH, tick is constant 1 while resetn is high.
  - tick = 0 while resetn is low.
- Not defined:
  - Port tick does not exist and no related logic is built.
  - Behaviour of counter_value and out is identical in both builds.

Test Plan:
- Reset hold: default params; clk running, resetn low 100 time units (10 edges) -> counter_value = 0x00000000 and out = 0x00 throughout; asynchronous assertion, with counter_value cleared before the next clk edge.
- Count after release: default params; release resetn between edges -> counter_value reads 1, 2, 3, ... on successive edges; out stays 0x00 for the first 2^24-1 edges.
- Output slice: WIDTH=8, OUT_WIDTH=4 -> out steps 0x0 to 0x1 on the 16th edge after release, and to 0x2 on the 32nd.
- Wrap: WIDTH=4, OUT_WIDTH=2 -> after 15 edges counter_value = 0xF and out = 0x3; the 16th edge gives counter_value = 0x0 and out = 0x0.
- Mid-count reset: WIDTH=8; count to 0x37, pulse resetn low for 3 ns between edges -> counter_value = 0 immediately; after release, 1 on the first edge.
- Tick (UP_COUNTER_TICK_EN defined): WIDTH=6, OUT_WIDTH=2 -> tick high only when counter_value = 15, 31, 47, 63; out changes on the edge that follows each tick.

Source files
------------

// File: rtl/up_counter.sv
// up_counter: free-running WIDTH-bit binary counter; out is its OUT_WIDTH MSBs.
// Ports: clk, resetn (async, active-low), out[OUT_WIDTH-1:0].
// Optional tick output built only when UP_COUNTER_TICK_EN is defined.
module up_counter #(
  parameter int WIDTH     = 32,
  parameter int OUT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 resetn,
  output logic [OUT_WIDTH-1:0] out
`ifdef UP_COUNTER_TICK_EN
  ,
  output logic                 tick
`endif
);

  if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
    $error("up_counter: WIDTH=%0d outside 1..64", WIDTH);
  end

  if (OUT_WIDTH < 1 || OUT_WIDTH > WIDTH) begin : g_bad_out
    $error("up_counter: OUT_WIDTH=%0d outside 1..WIDTH=%0d",
           OUT_WIDTH, WIDTH);
  end

  logic [WIDTH-1:0] counter_value;
  logic [WIDTH-1:0] counter_d;

  // Wraps naturally modulo 2^WIDTH.
  assign counter_d = counter_value + WIDTH'(1);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      counter_value <= '0;
    end else begin
      counter_value <= counter_d;
    end
  end

  // No register stage: out tracks counter_value with zero latency.
  assign out = counter_value[WIDTH-1 -: OUT_WIDTH];

`ifdef UP_COUNTER_TICK_EN
  // tick flags that out advances on the next edge.
  if (OUT_WIDTH == WIDTH) begin : g_tick_full
    assign tick = resetn;
  end else begin : g_tick_part
    assign tick = resetn & (&counter_value[WIDTH-OUT_WIDTH-1:0]);
  end
`endif

endmodule

// File: tb/tb_up_counter.sv
// tb_up_counter: randomized self-checking bench for up_counter.
// Five instances with different WIDTH/OUT_WIDTH share clk and resetn.
module tb_up_counter;

  localparam int NI = 5;
  localparam int WS [NI] = '{32, 8, 4, 8, 6};
  localparam int OS [NI] = '{8, 4, 2, 8, 2};

  logic       clk;
  logic       resetn;
  logic [7:0] out0;
  logic [3:0] out1;
  logic [1:0] out2;
  logic [7:0] out3;
  logic [1:0] out4;
  logic [NI-1:0] tk;

  int checks;
  int errors;
  logic [63:0] n;
  bit in_rst;

  logic [63:0] act_cnt [NI];
  logic [63:0] act_out [NI];

  up_counter uut (
    .clk(clk), .resetn(resetn), .out(out0)
`ifdef UP_COUNTER_TICK_EN
    , .tick(tk[0])
`endif
  );
  up_counter #(.WIDTH(8), .OUT_WIDTH(4)) u1 (
    .clk(clk), .resetn(resetn), .out(out1)
`ifdef UP_COUNTER_TICK_EN
    , .tick(tk[1])
`endif
  );
  up_counter #(.WIDTH(4), .OUT_WIDTH(2)) u2 (
    .clk(clk), .resetn(resetn), .out(out2)
`ifdef UP_COUNTER_TICK_EN
    , .tick(tk[2])
`endif
  );
  up_counter #(.WIDTH(8), .OUT_WIDTH(8)) u3 (
    .clk(clk), .resetn(resetn), .out(out3)
`ifdef UP_COUNTER_TICK_EN
    , .tick(tk[3])
`endif
  );
  up_counter #(.WIDTH(6), .OUT_WIDTH(2)) u4 (
    .clk(clk), .resetn(resetn), .out(out4)
`ifdef UP_COUNTER_TICK_EN
    , .tick(tk[4])
`endif
  );

`ifndef UP_COUNTER_TICK_EN
  assign tk = '0;
`endif

  always_comb begin
    act_cnt[0] = 64'(uut.counter_value);
    act_cnt[1] = 64'(u1.counter_value);
    act_cnt[2] = 64'(u2.counter_value);
    act_cnt[3] = 64'(u3.counter_value);
    act_cnt[4] = 64'(u4.counter_value);
    act_out[0] = 64'(out0);
    act_out[1] = 64'(out1);
    act_out[2] = 64'(out2);
    act_out[3] = 64'(out3);
    act_out[4] = 64'(out4);
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  // Reference model: n edges since release, count is n mod 2^W.
  function automatic logic [63:0] m_cnt(int k);
    if (in_rst) return 64'd0;
    return n % (64'd1 << WS[k]);
  endfunction

  function automatic logic [63:0] m_out(int k);
    return m_cnt(k) / (64'd1 << (WS[k] - OS[k]));
  endfunction

  function automatic logic m_tick(int k);
    logic [63:0] span;
    span = 64'd1 << (WS[k] - OS[k]);
    if (in_rst) return 1'b0;
    return (m_cnt(k) % span) == span - 1;
  endfunction

  task automatic step();
    @(posedge clk);
    if (!in_rst) n = n + 1;
    #1;
  endtask

  task automatic rst_on();
    resetn = 1'b0;
    in_rst = 1'b1;
    n = 0;
  endtask

  task automatic rst_off();
    resetn = 1'b1;
    in_rst = 1'b0;
    n = 0;
  endtask

  task automatic test_reset();
    rst_on();
    #1;
    for (int e = 0; e <= 10; e++) begin
      for (int k = 0; k < NI; k++) begin
        checks++;
        if (act_cnt[k] !== m_cnt(k)) begin
          errors++;
          $display("FAIL reset_cnt u%0d e%0d got %0h want %0h",
                   k, e, act_cnt[k], m_cnt(k));
        end
        checks++;
        if (act_out[k] !== m_out(k)) begin
          errors++;
          $display("FAIL reset_out u%0d e%0d got %0h want %0h",
                   k, e, act_out[k], m_out(k));
        end
      end
      step();
    end
  endtask

  task automatic test_count();
    @(negedge clk);
    rst_off();
    repeat (40) begin
      step();
      for (int k = 0; k < NI; k++) begin
        checks++;
        if (act_cnt[k] !== m_cnt(k)) begin
          errors++;
          $display("FAIL count_cnt u%0d n%0d got %0h want %0h",
                   k, n, act_cnt[k], m_cnt(k));
        end
        checks++;
        if (act_out[k] !== m_out(k)) begin
          errors++;
          $display("FAIL count_out u%0d n%0d got %0h want %0h",
                   k, n, act_out[k], m_out(k));
        end
      end
      if (n == 15) begin
        checks++;
        if (act_cnt[2] !== 64'hF || out2 !== 2'h3) begin
          errors++;
          $display("FAIL wrap_pre got %0h/%0h want f/3",
                   act_cnt[2], out2);
        end
      end
      if (n == 16) begin
        checks++;
        if (act_cnt[2] !== 64'h0 || out2 !== 2'h0) begin
          errors++;
          $display("FAIL wrap_post got %0h/%0h want 0/0",
                   act_cnt[2], out2);
        end
        checks++;
        if (out1 !== 4'h1) begin
          errors++;
          $display("FAIL slice16 got %0h want 1", out1);
        end
      end
      if (n == 32) begin
        checks++;
        if (out1 !== 4'h2) begin
          errors++;
          $display("FAIL slice32 got %0h want 2", out1);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    repeat (15) step();
    checks++;
    if (act_cnt[1] !== 64'h37) begin
      errors++;
      $display("FAIL mid_pre got %0h want 37", act_cnt[1]);
    end
    #1;
    rst_on();
    #1;
    for (int k = 0; k < NI; k++) begin
      checks++;
      if (act_cnt[k] !== 64'd0 || act_out[k] !== 64'd0) begin
        errors++;
        $display("FAIL mid_async u%0d got %0h/%0h want 0/0",
                 k, act_cnt[k], act_out[k]);
      end
    end
    #2;
    rst_off();
    step();
    for (int k = 0; k < NI; k++) begin
      checks++;
      if (act_cnt[k] !== 64'd1) begin
        errors++;
        $display("FAIL mid_first u%0d got %0h want 1",
                 k, act_cnt[k]);
      end
    end
  endtask

  task automatic test_random();
    int len;
    int a;
    int h;
    int w;
    for (int it = 0; it < 8; it++) begin
      len = int'($urandom_range(3, 70));
      repeat (len) begin
        step();
        for (int k = 0; k < NI; k++) begin
          checks++;
          if (act_cnt[k] !== m_cnt(k)) begin
            errors++;
            $display("FAIL rand_cnt u%0d it%0d got %0h want %0h",
                     k, it, act_cnt[k], m_cnt(k));
          end
          checks++;
          if (act_out[k] !== m_out(k)) begin
            errors++;
            $display("FAIL rand_out u%0d it%0d got %0h want %0h",
                     k, it, act_out[k], m_out(k));
          end
        end
      end
      a = int'($urandom_range(1, 4));
      #a;
      rst_on();
      #1;
      h = int'($urandom_range(0, 3));
      for (int e = 0; e <= h; e++) begin
        if (e > 0) step();
        for (int k = 0; k < NI; k++) begin
          checks++;
          if (act_cnt[k] !== 64'd0 || act_out[k] !== 64'd0) begin
            errors++;
            $display("FAIL rand_rst u%0d it%0d got %0h/%0h want 0/0",
                     k, it, act_cnt[k], act_out[k]);
          end
        end
      end
      w = int'($urandom_range(1, 3));
      #w;
      rst_off();
    end
  endtask

`ifdef UP_COUNTER_TICK_EN
  task automatic test_tick();
    logic [1:0] p_out;
    logic       p_tk;
    @(negedge clk);
    rst_on();
    #1;
    checks++;
    if (tk !== '0) begin
      errors++;
      $display("FAIL tick_rst got %b want 0", tk);
    end
    @(negedge clk);
    rst_off();
    #1;
    p_out = out4;
    p_tk  = tk[4];
    repeat (140) begin
      step();
      checks++;
      if ((out4 != p_out) !== p_tk) begin
        errors++;
        $display("FAIL tick_adv n%0d got %b want %b",
                 n, out4 != p_out, p_tk);
      end
      for (int k = 0; k < NI; k++) begin
        checks++;
        if (tk[k] !== m_tick(k)) begin
          errors++;
          $display("FAIL tick u%0d n%0d got %b want %b",
                   k, n, tk[k], m_tick(k));
        end
      end
      p_out = out4;
      p_tk  = tk[4];
    end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    n = 0;
    in_rst = 1'b1;
    resetn = 1'b0;
    test_reset();
    test_count();
    test_mid_reset();
    test_random();
`ifdef UP_COUNTER_TICK_EN
    test_tick();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
